// File: rtl/decode_stage.sv
// Instruction-decode stage: IF/ID register, bypassed register file, control decode,
// branch/jump resolution and load-use / branch hazard stalls feeding a registered ID/EX bundle.
module decode_stage #(
  parameter int PC_W   = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr_in,
  input  logic [PC_W-1:0]   pc_in,
  input  logic              wb_we,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              exmem_reg_write,
  input  logic [4:0]        exmem_dst,
  output logic              fetch_en,
  output logic              redirect,
  output logic [PC_W-1:0]   redirect_pc,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_dst,
  output logic [2:0]        ex_alu_op,
  output logic              ex_alu_src_imm,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_reg_write
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  logic [31:0]       if_instr;
  logic [PC_W-1:0]   if_pc;
  logic [DATA_W-1:0] rf [32];

  opcode_e           opcode;
  logic [4:0]        rs, rt, rd;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] rs_data, rt_data;

  alu_op_e    d_alu_op;
  logic       d_src_imm, d_mem_read, d_mem_write, d_reg_write;
  logic [4:0] d_dst;
  logic       is_beq, is_bne, is_j, reads_rs, reads_rt;
  logic       load_use, br_hazard, stall, taken;
  logic [PC_W-1:0] br_target;

  assign opcode  = opcode_e'(if_instr[31:26]);
  assign rs      = if_instr[25:21];
  assign rt      = if_instr[20:16];
  assign rd      = if_instr[15:11];
  assign imm_ext = {{(DATA_W-16){if_instr[15]}}, if_instr[15:0]};

  // Writeback in the same cycle is forwarded so the register file acts write-before-read.
  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (rs != 5'd0) rs_data = (wb_we && wb_addr == rs) ? wb_data : rf[rs];
    if (rt != 5'd0) rt_data = (wb_we && wb_addr == rt) ? wb_data : rf[rt];
  end

  always_comb begin
    d_alu_op    = ALU_ADD;
    d_src_imm   = 1'b0;
    d_mem_read  = 1'b0;
    d_mem_write = 1'b0;
    d_reg_write = 1'b0;
    d_dst       = '0;
    is_beq      = 1'b0;
    is_bne      = 1'b0;
    is_j        = 1'b0;
    reads_rs    = 1'b0;
    reads_rt    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        d_reg_write = 1'b1;
        case (if_instr[5:0])
          6'h20:   d_alu_op = ALU_ADD;
          6'h22:   d_alu_op = ALU_SUB;
          6'h24:   d_alu_op = ALU_AND;
          6'h25:   d_alu_op = ALU_OR;
          6'h2A:   d_alu_op = ALU_SLT;
          default: d_reg_write = 1'b0;
        endcase
        if (d_reg_write) begin
          d_dst    = rd;
          reads_rs = 1'b1;
          reads_rt = 1'b1;
        end
      end
      OP_ADDI: begin
        d_src_imm   = 1'b1;
        d_reg_write = 1'b1;
        d_dst       = rt;
        reads_rs    = 1'b1;
      end
      OP_LW: begin
        d_src_imm   = 1'b1;
        d_mem_read  = 1'b1;
        d_reg_write = 1'b1;
        d_dst       = rt;
        reads_rs    = 1'b1;
      end
      OP_SW: begin
        d_src_imm   = 1'b1;
        d_mem_write = 1'b1;
        reads_rs    = 1'b1;
        reads_rt    = 1'b1;
      end
      OP_BEQ: begin
        is_beq   = 1'b1;
        reads_rs = 1'b1;
        reads_rt = 1'b1;
      end
      OP_BNE: begin
        is_bne   = 1'b1;
        reads_rs = 1'b1;
        reads_rt = 1'b1;
      end
      OP_J:    is_j = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    load_use = ex_mem_read && (ex_dst != 5'd0) &&
               ((reads_rs && ex_dst == rs) || (reads_rt && ex_dst == rt));
    br_hazard = (is_beq || is_bne) &&
                ((ex_reg_write && ex_dst != 5'd0 && (ex_dst == rs || ex_dst == rt)) ||
                 (exmem_reg_write && exmem_dst != 5'd0 && (exmem_dst == rs || exmem_dst == rt)));
    stall     = load_use || br_hazard;
    taken     = (is_beq && rs_data == rt_data) || (is_bne && rs_data != rt_data);
    br_target = if_pc + if_instr[PC_W-1:0];
  end

  assign fetch_en    = rst || !stall;
  assign redirect    = !rst && !stall && (taken || is_j);
  assign redirect_pc = is_j ? if_instr[PC_W-1:0] : br_target;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_instr <= '0;
      if_pc    <= '0;
    end else if (redirect) begin
      if_instr <= '0;
      if_pc    <= '0;
    end else if (fetch_en) begin
      if_instr <= instr_in;
      if_pc    <= pc_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_we && wb_addr != 5'd0) begin
      rf[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || stall) begin
      ex_rs_data     <= '0;
      ex_rt_data     <= '0;
      ex_imm         <= '0;
      ex_rt          <= '0;
      ex_dst         <= '0;
      ex_alu_op      <= '0;
      ex_alu_src_imm <= 1'b0;
      ex_mem_read    <= 1'b0;
      ex_mem_write   <= 1'b0;
      ex_reg_write   <= 1'b0;
    end else begin
      ex_rs_data     <= rs_data;
      ex_rt_data     <= rt_data;
      ex_imm         <= imm_ext;
      ex_rt          <= rt;
      ex_dst         <= d_dst;
      ex_alu_op      <= d_alu_op;
      ex_alu_src_imm <= d_src_imm;
      ex_mem_read    <= d_mem_read;
      ex_mem_write   <= d_mem_write;
      ex_reg_write   <= d_reg_write;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage: the bench plays the fetch stage and the
// writeback/EX-MEM sources, checking hand-computed ID/EX and redirect values.
module tb_decode_stage;
  localparam int PC_W   = 7;
  localparam int DATA_W = 32;

  logic              clk, rst;
  logic [31:0]       instr_in;
  logic [PC_W-1:0]   pc_in;
  logic              wb_we;
  logic [4:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              exmem_reg_write;
  logic [4:0]        exmem_dst;
  logic              fetch_en, redirect;
  logic [PC_W-1:0]   redirect_pc;
  logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]        ex_rt, ex_dst;
  logic [2:0]        ex_alu_op;
  logic              ex_alu_src_imm, ex_mem_read, ex_mem_write, ex_reg_write;

  int n_cmp = 0;
  int n_err = 0;

  decode_stage #(.PC_W(PC_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .instr_in(instr_in), .pc_in(pc_in),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .exmem_reg_write(exmem_reg_write), .exmem_dst(exmem_dst),
    .fetch_en(fetch_en), .redirect(redirect), .redirect_pc(redirect_pc),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_rt(ex_rt), .ex_dst(ex_dst), .ex_alu_op(ex_alu_op),
    .ex_alu_src_imm(ex_alu_src_imm), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [5:0] fn_tab [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h21};
  logic [2:0] op_tab [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
  logic       we_tab [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    rst = 1'b1; instr_in = '0; pc_in = '0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    exmem_reg_write = 1'b0; exmem_dst = '0;
    #12;
    check_eq("rst_fetch_en", 32'(fetch_en), 32'd1);
    check_eq("rst_redirect", 32'(redirect), 32'd0);
    check_eq("rst_reg_write", 32'(ex_reg_write), 32'd0);
    check_eq("rst_imm", ex_imm, 32'd0);
    tick();
    rst = 1'b0;

    // addi r1,r0,5
    instr_in = 32'h20010005; pc_in = 7'd1; tick();
    instr_in = '0; pc_in = 7'd2; tick();
    check_eq("addi_imm", ex_imm, 32'd5);
    check_eq("addi_dst", 32'(ex_dst), 32'd1);
    check_eq("addi_we", 32'(ex_reg_write), 32'd1);
    check_eq("addi_src", 32'(ex_alu_src_imm), 32'd1);
    check_eq("addi_op", 32'(ex_alu_op), 32'd0);

    // addi r1,r0,-1 : sign extension
    instr_in = 32'h2001FFFF; tick();
    instr_in = '0; tick();
    check_eq("sext_imm", ex_imm, 32'hFFFFFFFF);

    for (int i = 0; i < 6; i++) begin
      instr_in = {6'h00, 5'd0, 5'd0, 5'd8, 5'd0, fn_tab[i]}; tick();
      instr_in = '0; tick();
      check_eq($sformatf("funct%0h_op", fn_tab[i]), 32'(ex_alu_op), 32'(op_tab[i]));
      check_eq($sformatf("funct%0h_we", fn_tab[i]), 32'(ex_reg_write), 32'(we_tab[i]));
    end
    instr_in = 32'hFC000000; tick();
    instr_in = '0; tick();
    check_eq("badop_we", 32'(ex_reg_write), 32'd0);

    // add r3,r2,r2 with r2 written in the same cycle
    instr_in = 32'h00421820; tick();
    instr_in = '0; wb_we = 1'b1; wb_addr = 5'd2; wb_data = 32'hDEAD; tick();
    wb_we = 1'b0;
    check_eq("byp_rs", ex_rs_data, 32'hDEAD);
    check_eq("byp_rt", ex_rt_data, 32'hDEAD);
    check_eq("byp_dst", 32'(ex_dst), 32'd3);
    instr_in = 32'h00421820; tick();
    instr_in = '0; tick();
    check_eq("rf_r2", ex_rs_data, 32'hDEAD);

    // write r0 while add r7,r0,r0 decodes
    instr_in = 32'h00003820; wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234; tick();
    instr_in = '0; tick();
    wb_we = 1'b0;
    check_eq("r0_rs", ex_rs_data, 32'd0);
    check_eq("r0_rt", ex_rt_data, 32'd0);
    check_eq("r0_dst", 32'(ex_dst), 32'd7);

    // lw r4,0(r1) ; add r5,r4,r4
    instr_in = 32'h8C240000; tick();
    instr_in = 32'h00842820; tick();
    check_eq("lw_rd", 32'(ex_mem_read), 32'd1);
    check_eq("lw_dst", 32'(ex_dst), 32'd4);
    check_eq("lu_fetch_en", 32'(fetch_en), 32'd0);
    tick();
    check_eq("lu_bub_we", 32'(ex_reg_write), 32'd0);
    check_eq("lu_bub_rd", 32'(ex_mem_read), 32'd0);
    check_eq("lu_bub_src", 32'(ex_alu_src_imm), 32'd0);
    check_eq("lu_resume_en", 32'(fetch_en), 32'd1);
    instr_in = '0; tick();
    check_eq("lu_add_dst", 32'(ex_dst), 32'd5);
    check_eq("lu_add_we", 32'(ex_reg_write), 32'd1);

    // sw r2,4(r1)
    instr_in = 32'hAC220004; tick();
    instr_in = '0; tick();
    check_eq("sw_wr", 32'(ex_mem_write), 32'd1);
    check_eq("sw_we", 32'(ex_reg_write), 32'd0);
    check_eq("sw_imm", ex_imm, 32'd4);
    check_eq("sw_rt", 32'(ex_rt), 32'd2);

    // r1 = r2 = 7
    wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'd7; tick();
    wb_addr = 5'd2; tick();
    wb_we = 1'b0;

    // beq r1,r2,+3 at pc 10; the next fetched addi must be flushed
    instr_in = 32'h10220003; pc_in = 7'd10; tick();
    check_eq("beq_redir", 32'(redirect), 32'd1);
    check_eq("beq_pc", 32'(redirect_pc), 32'd13);
    check_eq("beq_fetch_en", 32'(fetch_en), 32'd1);
    instr_in = 32'h20090001; pc_in = 7'd11; tick();
    check_eq("beq_redir_1cyc", 32'(redirect), 32'd0);
    check_eq("beq_idex_we", 32'(ex_reg_write), 32'd0);
    check_eq("beq_idex_rd", 32'(ex_mem_read), 32'd0);
    instr_in = '0; tick();
    check_eq("flush_we", 32'(ex_reg_write), 32'd0);
    check_eq("flush_dst", 32'(ex_dst), 32'd0);

    // bne r1,r2 (equal -> not taken), bne r1,r0,+1 at pc 20 (taken)
    instr_in = 32'h14220003; pc_in = 7'd10; tick();
    check_eq("bne_nt", 32'(redirect), 32'd0);
    instr_in = 32'h14200001; pc_in = 7'd20; tick();
    check_eq("bne_t", 32'(redirect), 32'd1);
    check_eq("bne_pc", 32'(redirect_pc), 32'd21);
    instr_in = '0; tick();

    // beq wrap and j
    instr_in = 32'h10220002; pc_in = 7'd127; tick();
    check_eq("wrap_redir", 32'(redirect), 32'd1);
    check_eq("wrap_pc", 32'(redirect_pc), 32'd1);
    instr_in = '0; tick();
    instr_in = 32'h08000045; tick();
    check_eq("j_redir", 32'(redirect), 32'd1);
    check_eq("j_pc", 32'(redirect_pc), 32'h45);
    instr_in = '0; tick();

    // beq r6,r0,+0 with EX/MEM writing r6: one-cycle stall then taken
    instr_in = 32'h10C00000; pc_in = 7'd40; exmem_reg_write = 1'b1; exmem_dst = 5'd6; tick();
    check_eq("bh_fetch_en", 32'(fetch_en), 32'd0);
    check_eq("bh_redir", 32'(redirect), 32'd0);
    exmem_reg_write = 1'b0; #1;
    check_eq("bh_clear_en", 32'(fetch_en), 32'd1);
    check_eq("bh_clear_redir", 32'(redirect), 32'd1);
    check_eq("bh_clear_pc", 32'(redirect_pc), 32'd40);
    instr_in = '0; tick();

    // addi r9,r0,3 then stalled beq; reset asserted mid-stall
    instr_in = 32'h20090003; tick();
    instr_in = 32'h10C00000; exmem_reg_write = 1'b1; tick();
    check_eq("pre_rst_stall", 32'(fetch_en), 32'd0);
    check_eq("pre_rst_we", 32'(ex_reg_write), 32'd1);
    check_eq("pre_rst_imm", ex_imm, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_fetch_en", 32'(fetch_en), 32'd1);
    check_eq("arst_redir", 32'(redirect), 32'd0);
    check_eq("arst_we", 32'(ex_reg_write), 32'd0);
    check_eq("arst_dst", 32'(ex_dst), 32'd0);
    check_eq("arst_imm", ex_imm, 32'd0);
    check_eq("arst_src", 32'(ex_alu_src_imm), 32'd0);
    check_eq("arst_pc", 32'(redirect_pc), 32'd0);
    tick();
    rst = 1'b0; exmem_reg_write = 1'b0;

    // add r10,r1,r2 after reset: registers cleared
    instr_in = 32'h00225020; tick();
    instr_in = '0; tick();
    check_eq("post_rst_rs", ex_rs_data, 32'd0);
    check_eq("post_rst_rt", ex_rt_data, 32'd0);
    check_eq("post_rst_dst", 32'(ex_dst), 32'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode stage that sits directly downstream of the fetch stage. It consumes the 32-bit instruction word and the incremented PC.
- Contains the IF/ID register, a 32x32 register file with write-before-read bypass, main control decode, branch/jump resolution, and load-use / branch-hazard detection.
- Drives the fetch stage's enable (stall) and redirect (dec, pc_mux) inputs.
- Produces a registered ID/EX bundle for the execute stage.

Parameters:
- PC_W, 7, width of PC and branch/jump targets (word addressed).
- DATA_W, 32, instruction and register data width.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous, active-high reset.
- instr_in, in, 32, instruction from fetch (0 = nop).
- pc_in, in, PC_W, PC+1 from fetch.
- wb_we, in, 1, writeback register write enable.
- wb_addr, in, 5, writeback destination register.
- wb_data, in, DATA_W, writeback data.
- exmem_reg_write, in, 1, EX/MEM instruction writes a register.
- exmem_dst, in, 5, EX/MEM destination register.
- fetch_en, out, 1, 0 = hold PC; connects to fetch enbl.
- redirect, out, 1, branch/jump taken; connects to fetch dec.
- redirect_pc, out, PC_W, target PC; connects to fetch pc_mux.
- ex_rs_data, out, DATA_W, registered rs value.
- ex_rt_data, out, DATA_W, registered rt value.
- ex_imm, out, DATA_W, registered sign-extended imm[15:0].
- ex_rt, out, 5, registered rt field.
- ex_dst, out, 5, registered destination register (rd for R-type, rt for I-type).
- ex_alu_op, out, 3, ALU function: 0 add, 1 sub, 2 and, 3 or, 4 slt.
- ex_alu_src_imm, out, 1, use ex_imm as ALU operand B.
- ex_mem_read, out, 1, registered memory read.
- ex_mem_write, out, 1, registered memory write.
- ex_reg_write, out, 1, registered register write.

Behaviour:

Reset:
- IF/ID instr and pc, all ID/EX outputs, and all 32 registers clear to 0.
- While rst is high: fetch_en=1, redirect=0.

Decode set (instr[31:26]):
- 0x00 R-type, funct 0x20 add / 0x22 sub / 0x24 and / 0x25 or / 0x2A slt.
- 0x08 addi; 0x23 lw; 0x2B sw; 0x04 beq; 0x05 bne; 0x02 j.
- Any other opcode or funct decodes as a nop: all control signals 0.
- Instruction word 0x00000000 is a nop; its write to r0 is suppressed.

IF/ID register:
- On each clk, loads instr_in and pc_in when fetch_en=1.
- Holds its contents when fetch_en=0.
- Loads 0 when redirect=1; redirect has priority over a hold.

Register file:
- 2 combinational read ports (rs, rt) and 1 synchronous write port (wb_*).
- r0 always reads 0 and writes to it are ignored.
- If wb_we=1, wb_addr==rs or rt, and the address is nonzero, the read returns wb_data in the same cycle (bypass).

Load-use hazard:
- Condition: ID/EX has ex_mem_read=1, ex_dst != 0, and ex_dst == rs (any opcode that reads rs) or ex_dst == rt (R-type, sw, beq, bne).

Branch hazard:
- Condition: IF/ID holds beq or bne, and either ID/EX (ex_reg_write, ex_dst) or EX/MEM (exmem_reg_write, exmem_dst) writes a nonzero register equal to rs or rt.

Stall:
- stall = load-use hazard OR branch hazard.
- On stall: fetch_en=0, IF/ID holds, ID/EX loads a bubble (all control signals 0, data fields 0), redirect=0.

Branch resolution (combinational, only when stall=0):
- beq taken if rs_data == rt_data; bne taken if they differ.
- Branch target = IF/ID pc + imm[PC_W-1:0], modulo 2^PC_W (wraps).
- j: redirect_pc = instr[PC_W-1:0].
- redirect=1 for one cycle; fetch_en stays 1.
- Branch penalty is 1 cycle: the instruction fetched in the redirect cycle is discarded because IF/ID is flushed.

ID/EX register:
- Loads the decoded fields each cycle when stall=0.
- Branches and j enter ID/EX as nops (no write, no memory access).

Reset mid-operation:
- Asynchronous clear of all state; the pipeline resumes from the nop state with no pending stall.

Test Plan:
1. Reset, then feed addi r1,r0,5 (0x20010005) with pc_in=1 → next cycle ex_imm=5, ex_dst=1, ex_reg_write=1, ex_alu_src_imm=1, ex_alu_op=0.
2. wb_we=1, wb_addr=2, wb_data=0xDEAD in the same cycle IF/ID holds add r3,r2,r2 → ex_rs_data = ex_rt_data = 0xDEAD after the clock (bypass); a write to r0 then a read of r0 → 0.
3. lw r4,0(r1) followed by add r5,r4,r4 → one cycle with fetch_en=0 and an ID/EX bubble (all control 0); the add issues on the next cycle with ex_dst=5.
4. r1=r2=7, IF/ID pc=10, beq r1,r2,+3 → redirect=1, redirect_pc=13; the following cycle IF/ID holds 0 and ID/EX is a nop. Same with bne → redirect=0.
5. IF/ID pc=127, beq taken, imm=2 → redirect_pc=1 (wrap). j 0x45 → redirect_pc=0x45.
6. beq r6,r0 with exmem_reg_write=1, exmem_dst=6 → stall for 1 cycle, redirect=0; assert rst mid-stall → all outputs 0 and fetch_en=1 immediately (asynchronous).
